// File: rtl/cci_delta_gen_pkg.sv
// Shared types and constants for the CCI delta generator and the downstream distortion stage.
package cci_delta_gen_pkg;

    typedef logic signed [15:0] delta_t;

    // Voltages are unsigned fixed point with this many fractional bits.
    localparam int unsigned VoltFracBits = 11;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StFlush,
        StDone
    } state_e;

endpackage

// File: rtl/cci_delta_sat.sv
// Combinational aggressor delta: 17-bit signed subtract, saturated to 16 bits signed.
module cci_delta_sat
    import cci_delta_gen_pkg::*;
(
    input  logic [15:0] after_i,
    input  logic [15:0] before_i,
    output delta_t      delta_o
);

    localparam logic signed [16:0] SatMax = 17'sd32767;
    localparam logic signed [16:0] SatMin = -17'sd32768;

    logic signed [16:0] diff;

    assign diff = $signed({1'b0, after_i}) - $signed({1'b0, before_i});

    always_comb begin
        if (diff > SatMax) begin
            delta_o = 16'sh7FFF;
        end else if (diff < SatMin) begin
            delta_o = 16'sh8000;
        end else begin
            delta_o = diff[15:0];
        end
    end

endmodule

// File: rtl/cci_delta_gen.sv
// Streams one wordline of cells, emitting per victim the left/vertical/right aggressor deltas,
// paced so successive outEn strobes are at least MIN_GAP cycles apart.
module cci_delta_gen
    import cci_delta_gen_pkg::*;
#(
    parameter int unsigned NUM_BL  = 32,
    parameter int unsigned MIN_GAP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] aggressorVoltage,
    input  logic [31:0] victimVoltage,
    output logic        outEn,
    output logic [31:0] outVictimVoltage,
    output logic [15:0] XY_CCI_left,
    output logic [15:0] Y_CCI,
    output logic [15:0] XY_CCI_right,
    output logic        rowDone
);

    localparam int unsigned IdxW = (NUM_BL > 1) ? $clog2(NUM_BL) : 1;
    localparam int unsigned GapW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BL - 1);
    localparam logic [GapW-1:0] GapLoad = GapW'(MIN_GAP - 1);

    state_e          state_q, state_d;
    delta_t          d_prev_q, d_prev_d;
    delta_t          d_cur_q, d_cur_d;
    logic [31:0]     v_cur_q, v_cur_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [GapW-1:0] gap_q, gap_d;
    delta_t          left_q, left_d;
    delta_t          y_q, y_d;
    delta_t          right_q, right_d;
    logic [31:0]     vic_q, vic_d;
    logic            en_q, en_d;
    logic            done_q, done_d;
    delta_t          d_new;
    logic            accept;

    cci_delta_sat u_sat (
        .after_i  (aggressorVoltage[31:16]),
        .before_i (aggressorVoltage[15:0]),
        .delta_o  (d_new)
    );

    // A registered strobe counts as pending, so a new sample waits for both it and the gap.
    always_comb begin
        inReady = 1'b0;
        unique case (state_q)
            StFill:  inReady = 1'b1;
            StRun:   inReady = (gap_q == '0) && !en_q;
            default: inReady = 1'b0;
        endcase
    end

    assign accept = inValid && inReady;

    always_comb begin
        state_d  = state_q;
        d_prev_d = d_prev_q;
        d_cur_d  = d_cur_q;
        v_cur_d  = v_cur_q;
        idx_d    = idx_q;
        left_d   = left_q;
        y_d      = y_q;
        right_d  = right_q;
        vic_d    = vic_q;
        en_d     = 1'b0;
        done_d   = 1'b0;
        gap_d    = (gap_q != '0) ? gap_q - 1'b1 : gap_q;

        // start wins over everything, including a sample accepted in the same cycle.
        if (start) begin
            state_d  = StFill;
            d_prev_d = '0;
            d_cur_d  = '0;
            v_cur_d  = '0;
            idx_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StFill: begin
                    if (accept) begin
                        d_cur_d = d_new;
                        v_cur_d = victimVoltage;
                        idx_d   = idx_q + 1'b1;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (accept) begin
                        en_d     = 1'b1;
                        gap_d    = GapLoad;
                        left_d   = d_prev_q;
                        y_d      = d_cur_q;
                        right_d  = d_new;
                        vic_d    = v_cur_q;
                        d_prev_d = d_cur_q;
                        d_cur_d  = d_new;
                        v_cur_d  = victimVoltage;
                        if (idx_q == LastIdx) begin
                            state_d = StFlush;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (gap_q == '0) begin
                        en_d    = 1'b1;
                        gap_d   = GapLoad;
                        left_d  = d_prev_q;
                        y_d     = d_cur_q;
                        right_d = '0;
                        vic_d   = v_cur_q;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            d_prev_q <= '0;
            d_cur_q  <= '0;
            v_cur_q  <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            left_q   <= '0;
            y_q      <= '0;
            right_q  <= '0;
            vic_q    <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_prev_q <= d_prev_d;
            d_cur_q  <= d_cur_d;
            v_cur_q  <= v_cur_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            left_q   <= left_d;
            y_q      <= y_d;
            right_q  <= right_d;
            vic_q    <= vic_d;
            en_q     <= en_d;
            done_q   <= done_d;
        end
    end

    assign outEn            = en_q;
    assign rowDone          = done_q;
    assign outVictimVoltage = vic_q;
    assign XY_CCI_left      = left_q;
    assign Y_CCI            = y_q;
    assign XY_CCI_right     = right_q;

endmodule

// File: doc/cci_delta_gen.md
Name: cci_delta_gen

Overview:
- Upstream feeder for the cell-to-cell interference (CCI) distortion stage.
- Consumes one wordline of cells in bitline order. Each cell arrives as an aggressor voltage pair (next wordline, after/before programming) plus its victim voltage.
- Computes signed aggressor deltas and uses a 3-wide sliding window to emit, per victim, the left-diagonal, vertical and right-diagonal deltas.
- Paces the emit strobes so the distortion stage's fixed 4-cycle sequence is never overrun.

Parameters:
- NUM_BL, 32, bitlines per wordline (>=2).
- MIN_GAP, 4, minimum clk cycles between successive outEn strobes (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse; begins a new wordline.
- inValid  input  1  sample valid.
- inReady  output  1  sample accepted when inValid && inReady.
- aggressorVoltage  input  32  [31:16] voltage after program, [15:0] voltage before; unsigned, 11 fractional bits.
- victimVoltage  input  32  victim cell word, passed through unchanged.
- outEn  output  1  one-cycle strobe; drives the distortion stage enable.
- outVictimVoltage  output  32  victim word aligned with outEn.
- XY_CCI_left  output  16  signed delta of bitline i-1.
- Y_CCI  output  16  signed delta of bitline i.
- XY_CCI_right  output  16  signed delta of bitline i+1.
- rowDone  output  1  one-cycle pulse after the last victim of a wordline.

Behaviour:
- Reset values: all outputs 0; state IDLE; window, index and gap counter cleared. Asserting rst_n low mid-row drops the row immediately, with no further outEn.
- Delta computation:
  - d = after - before, computed at 17 bits signed.
  - Saturate to [-32768, 32767]; no wrap.
- States:
  - IDLE: inReady=0. start moves to FILL, clearing the window (dPrev=dCur=0) and setting idx=0.
  - FILL: inReady=1. Accept sample 0, store dCur/vCur, idx=1, then go to RUN. Sample 0 triggers no emit.
  - RUN:
    - inReady = (gapCnt==0) && !pending.
    - Accepting sample k raises pending. Next cycle: outEn=1 for victim k-1 with left=dPrev, Y=dCur, right=d(k), outVictimVoltage=vCur. The window then shifts.
    - If k==NUM_BL-1, go to FLUSH; else idx++.
  - FLUSH: when gapCnt==0, emit victim NUM_BL-1 with left=dPrev, Y=dCur, right=0. Then go to DONE.
  - DONE: rowDone=1 for one cycle, then IDLE.
- Boundaries:
  - Victim 0 always has left=0.
  - Victim NUM_BL-1 always has right=0.
- Pacing:
  - gapCnt loads MIN_GAP-1 on every outEn and decrements to 0.
  - outEn never occurs with gapCnt!=0. Successive strobes are therefore >= MIN_GAP cycles apart.
- Timing:
  - Latency from acceptance of sample k (k>=1) to its outEn: exactly 1 cycle.
  - rowDone follows the final outEn by 1 cycle.
  - Exactly NUM_BL strobes per row.
- Outputs hold between strobes. Only outEn and rowDone are pulses.
- start in any state other than IDLE aborts the current row: window is cleared, no rowDone, state goes to FILL. start coincident with a sample acceptance takes priority, and that sample is ignored.
- inValid while inReady=0 has no effect. Upstream holds data until accepted.
- idx counter width is clog2(NUM_BL). It never wraps within a row and resets on start.

Decomposition:
- Shared package holds:
  - typedef signed 16-bit delta;
  - constant voltage fractional bits = 11;
  - state enum {IDLE, FILL, RUN, FLUSH, DONE}.
- One natural sub-module: cci_delta_sat, the combinational 17-bit subtract plus 16-bit saturate. It is reusable by the downstream stage.

Test Plan:
- NUM_BL=4, MIN_GAP=4, after/before pairs (0x1000,0x0E00), (0x0800,0x0900), (0x2000,0x1000), (0x0100,0x0100) give deltas 512, -256, 4096, 0.
  - Required triples (L,Y,R): (0,512,-256), (512,-256,4096), (-256,4096,0), (4096,0,0).
  - 4 outEn strobes, each 4 cycles apart; rowDone 1 cycle after the last strobe.
- Saturation:
  - after=0xFFFF, before=0x0000 -> Y_CCI=32767.
  - after=0x0000, before=0xFFFF -> Y_CCI=-32768.
- inValid held high continuously:
  - inReady is low for 3 cycles after each strobe.
  - Strobe spacing is exactly 4 cycles; no sample is lost or duplicated.
  - victimVoltage pass-through is bit-exact.
- start pulsed after 2 victims emitted:
  - No rowDone for the aborted row.
  - The new row's victim 0 has left=0 and is unaffected by old deltas.
- rst_n driven low mid-RUN for 1 cycle:
  - All outputs 0 asynchronously; no outEn until a fresh start.
  - A new row completes normally.
- MIN_GAP=1, NUM_BL=2: strobes on consecutive cycles allowed; exactly 2 strobes then rowDone.
